// File: rtl/div_err_mse_accumulator.sv
// Error-metric accumulator for one approximate/exact 16/8 divider pair.
// Over a batch of 2^LOG2_N samples it builds the sum of squared quotient
// errors, max |quotient error|, mismatch and divide-by-zero counts, and MSE.
module div_err_mse_accumulator #(
  parameter int unsigned LOG2_N  = 4,
  parameter bit          SKIP_DZ = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [7:0]          d,
  input  logic [7:0]          q_ex,
  input  logic [7:0]          r_ex,
  input  logic [7:0]          q_ap,
  input  logic [7:0]          r_ap,
  output logic                busy,
  output logic                done,
  output logic [16+LOG2_N-1:0] sse,
  output logic [15:0]         mse,
  output logic [7:0]          max_err,
  output logic [LOG2_N:0]     mism_cnt,
  output logic [LOG2_N:0]     dz_cnt
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e             state_q;
  logic [LOG2_N-1:0]  cnt_q;
  logic               accept;
  logic               batch_start;

  // Pipeline registers
  logic               v1_q, v2_q;
  logic [7:0]         a1_q, a2_q;
  logic               mm1_q, mm2_q;
  logic               dz1_q, dz2_q;
  logic [15:0]        sq2_q;

  logic [8:0]         err;
  logic [7:0]         abs_err;
  logic [16+LOG2_N-1:0] sse_nxt;
  logic               s3_update;

  assign accept      = in_valid && in_ready;
  assign batch_start = (state_q == StIdle) && start;

  // Quotient difference as 9-bit signed; |err| never exceeds 255.
  always_comb begin
    err     = {1'b0, q_ap} - {1'b0, q_ex};
    abs_err = err[8] ? (~err[7:0] + 8'd1) : err[7:0];
  end

  // Stage-3 next values; divide-by-zero samples only bump dz_cnt when skipped.
  always_comb begin
    s3_update = v2_q && !(dz2_q && SKIP_DZ);
    sse_nxt   = sse + {{LOG2_N{1'b0}}, sq2_q};
  end

  // Control FSM with registered in_ready/busy/done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            cnt_q    <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            state_q  <= StRun;
          end
        end
        StRun: begin
          if (accept) begin
            cnt_q <= cnt_q + 1'b1;
            // Last sample of the batch: counter wraps, stop accepting.
            if (cnt_q == {LOG2_N{1'b1}}) begin
              in_ready <= 1'b0;
              state_q  <= StDrain;
            end
          end
        end
        StDrain: begin
          if (!v1_q && !v2_q) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          done    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Stages 1 and 2: error magnitude/flags, then square.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      a1_q  <= '0;
      a2_q  <= '0;
      mm1_q <= 1'b0;
      mm2_q <= 1'b0;
      dz1_q <= 1'b0;
      dz2_q <= 1'b0;
      sq2_q <= '0;
    end else begin
      v1_q  <= accept;
      a1_q  <= abs_err;
      mm1_q <= (q_ap != q_ex) || (r_ap != r_ex);
      dz1_q <= (d == 8'd0);
      v2_q  <= v1_q;
      a2_q  <= a1_q;
      mm2_q <= mm1_q;
      dz2_q <= dz1_q;
      sq2_q <= {8'd0, a1_q} * {8'd0, a1_q};
    end
  end

  // Stage 3: accumulators, cleared when a new batch starts.
  always_ff @(posedge clk) begin
    if (rst || batch_start) begin
      sse      <= '0;
      mse      <= '0;
      max_err  <= '0;
      mism_cnt <= '0;
      dz_cnt   <= '0;
    end else if (v2_q) begin
      dz_cnt <= dz_cnt + {{LOG2_N{1'b0}}, dz2_q};
      if (s3_update) begin
        sse      <= sse_nxt;
        mse      <= sse_nxt[LOG2_N +: 16];
        mism_cnt <= mism_cnt + {{LOG2_N{1'b0}}, mm2_q};
        if (a2_q > max_err) max_err <= a2_q;
      end
    end
  end

endmodule

// File: tb/tb_div_err_mse_accumulator.sv
// Scoreboard bench for div_err_mse_accumulator with a 4-sample batch.
module tb_div_err_mse_accumulator;

  localparam int unsigned LOG2_N  = 2;
  localparam bit          SKIP_DZ = 1'b1;
  localparam int          N       = 1 << LOG2_N;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  start = 1'b0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [7:0]            d = '0, q_ex = '0, r_ex = '0, q_ap = '0, r_ap = '0;
  logic                  busy, done;
  logic [16+LOG2_N-1:0]  sse;
  logic [15:0]           mse;
  logic [7:0]            max_err;
  logic [LOG2_N:0]       mism_cnt, dz_cnt;

  typedef struct packed {
    logic [7:0] d, qex, rex, qap, rap;
  } samp_t;

  typedef struct {
    int sse, mse, mx, mm, dz;
  } exp_t;

  samp_t batch [N];
  exp_t  sb [$];
  int    n_tests = 0;
  int    n_fail  = 0;

  always #5 clk = ~clk;

  div_err_mse_accumulator #(
    .LOG2_N  (LOG2_N),
    .SKIP_DZ (SKIP_DZ)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .d        (d),
    .q_ex     (q_ex),
    .r_ex     (r_ex),
    .q_ap     (q_ap),
    .r_ap     (r_ap),
    .busy     (busy),
    .done     (done),
    .sse      (sse),
    .mse      (mse),
    .max_err  (max_err),
    .mism_cnt (mism_cnt),
    .dz_cnt   (dz_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model of one batch, pushed when the batch is driven.
  function automatic exp_t model();
    exp_t r;
    int   e;
    r = '{0, 0, 0, 0, 0};
    for (int i = 0; i < N; i++) begin
      if (batch[i].d == 8'd0) r.dz++;
      if (batch[i].d == 8'd0 && SKIP_DZ) continue;
      e = int'(batch[i].qap) - int'(batch[i].qex);
      if (e < 0) e = -e;
      r.sse += e * e;
      if (e > r.mx) r.mx = e;
      if (batch[i].qap != batch[i].qex || batch[i].rap != batch[i].rex) r.mm++;
    end
    r.mse = (r.sse >> LOG2_N) & 32'hffff;
    return r;
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t x;
        x = sb.pop_front();
        check("sse", 32'(sse), x.sse);
        check("mse", 32'(mse), x.mse);
        check("max_err", 32'(max_err), x.mx);
        check("mism_cnt", 32'(mism_cnt), x.mm);
        check("dz_cnt", 32'(dz_cnt), x.dz);
      end
    end
  end

  task automatic set_sample(input int i, input logic [7:0] dd, input logic [7:0] qe,
                            input logic [7:0] re, input logic [7:0] qa, input logic [7:0] ra);
    batch[i] = '{dd, qe, re, qa, ra};
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drive a full batch; optional random in_valid gaps and a stray start in RUN.
  task automatic run_batch(input bit gaps, input bit start_mid);
    int  idx = 0;
    int  budget = 0;
    bit  sp = 0;
    bit  want, acc;
    sb.push_back(model());
    pulse_start();
    check("in_ready_run", 32'(in_ready), 32'd1);
    while (idx < N && budget < 200) begin
      budget++;
      start = start_mid && idx == 2 && !sp;
      if (start) sp = 1;
      want = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (want) begin
        {d, q_ex, r_ex, q_ap, r_ap} = batch[idx];
        in_valid = 1'b1;
      end else begin
        {d, q_ex, r_ex, q_ap, r_ap} = 40'($urandom());
        {d, q_ex} = {d, q_ex} ^ 16'($urandom());
        in_valid = 1'b0;
      end
      acc = want && in_ready;
      @(posedge clk);
      if (acc) idx++;
      @(negedge clk);
    end
    start = 1'b0;
    in_valid = 1'b0;
    if (idx != N) check("accept_timeout", 32'(idx), N);
    // Last accept at edge k: done is high only after edge k+3.
    for (int n = 1; n <= 5; n++) begin
      if (n == 1) check("in_ready_after_last", 32'(in_ready), 32'd0);
      check($sformatf("done_cycle%0d", n), 32'(done), 32'(n == 4));
      @(negedge clk);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_sse"}, 32'(sse), 32'd0);
    check({tag, "_mse"}, 32'(mse), 32'd0);
    check({tag, "_max_err"}, 32'(max_err), 32'd0);
    check({tag, "_cnts"}, 32'({mism_cnt, dz_cnt}), 32'd0);
  endtask

  task automatic load_mixed();
    set_sample(0, 8'd7, 8'd10, 8'd1, 8'd11, 8'd1);
    set_sample(1, 8'd7, 8'd10, 8'd2, 8'd8,  8'd2);
    set_sample(2, 8'd7, 8'd5,  8'd3, 8'd8,  8'd3);
    set_sample(3, 8'd7, 8'd9,  8'd4, 8'd9,  8'd4);
  endtask

  task automatic load_max();
    for (int i = 0; i < N; i++) set_sample(i, 8'd1, 8'd0, 8'd0, 8'd255, 8'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 32'd0);

    // Exact match: all-zero error statistics.
    for (int i = 0; i < N; i++) set_sample(i, 8'd7, 8'(20 + i), 8'd3, 8'(20 + i), 8'd3);
    run_batch(1'b0, 1'b0);

    // Mixed errors: sse=14, mse=3, max_err=3, mism_cnt=3.
    load_mixed();
    run_batch(1'b0, 1'b0);

    // Worst case: sse=260100, mse=65025.
    load_max();
    run_batch(1'b0, 1'b0);

    // Divide-by-zero sample excluded from error stats.
    set_sample(0, 8'd3, 8'd10, 8'd0, 8'd11, 8'd0);
    set_sample(1, 8'd0, 8'd10, 8'd0, 8'd15, 8'd0);
    set_sample(2, 8'd3, 8'd40, 8'd1, 8'd41, 8'd1);
    set_sample(3, 8'd3, 8'd90, 8'd2, 8'd89, 8'd2);
    run_batch(1'b0, 1'b0);

    // Same mixed batch with in_valid gaps, then with a stray start in RUN.
    load_mixed();
    run_batch(1'b1, 1'b0);
    run_batch(1'b0, 1'b1);

    // Results hold in IDLE until the next start.
    repeat (3) @(negedge clk);
    check("hold_sse", 32'(sse), 32'd14);

    // Reset after two accepted samples: batch discarded, no done.
    pulse_start();
    for (int i = 0; i < 2; i++) begin
      {d, q_ex, r_ex, q_ap, r_ap} = batch[i];
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("abort");
    repeat (6) begin
      @(negedge clk);
      check("abort_no_done", 32'(done), 32'd0);
    end

    // Fresh batch after the abort.
    load_max();
    run_batch(1'b1, 1'b0);

    repeat (4) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
